dmem_arbiter: RTL

Two-requester arbiter and sequencer for the single-port data memory. It shares the memory between the CPU load/store port and an external requester, such as a program loader or debug/DMA agent. It sits between the CPU's execute-stage address/write-data outputs and the data memory, and its stall output holds the PC and register write-back while the CPU is denied. Features: fixed CPU priority, starvation guard for the external port, optional external bus lock, one-cycle read-return tracking.

---
 rtl/dmem_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing a single-port data memory between the CPU load/store port
// and an external requester, with starvation guard, bus lock and one-cycle read return.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_gnt,
  output logic          o_cpu_stall,
  output logic          o_cpu_rvalid,
  output logic [DW-1:0] o_cpu_rdata,
  input  logic          i_ext_req,
  input  logic          i_ext_we,
  input  logic          i_ext_lock,
  input  logic [AW-1:0] i_ext_addr,
  input  logic [DW-1:0] i_ext_wdata,
  output logic          o_ext_gnt,
  output logic          o_ext_rvalid,
  output logic [DW-1:0] o_ext_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic {S_NORM, S_LOCK} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       rd_vld_p1;
  logic       rd_ext_p1;
  logic       rd_xfer_p0;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= WAIT_MAX) ? WAIT_MAX : cnt + 4'd1;
  endfunction

  // Stage p0: combinational grant and memory bus steering in the request cycle
  always_comb begin
    o_cpu_gnt = 1'b0;
    o_ext_gnt = 1'b0;
    if (!i_rst) begin
      if (state == S_LOCK)
        o_ext_gnt = i_ext_req;
      else if (i_ext_req && (!i_cpu_req || wait_cnt == WAIT_MAX))
        o_ext_gnt = 1'b1;
      else
        o_cpu_gnt = i_cpu_req;
    end
  end

  assign o_cpu_stall = i_cpu_req & ~o_cpu_gnt;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (o_cpu_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_cpu_we;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (o_ext_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ext_we;
      o_mem_addr  = i_ext_addr;
      o_mem_wdata = i_ext_wdata;
    end
  end

  assign rd_xfer_p0 = (o_cpu_gnt & ~i_cpu_we) | (o_ext_gnt & ~i_ext_we);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_NORM;
      wait_cnt  <= 4'd0;
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_xfer_p0;
      if (i_ext_req && !o_ext_gnt)
        wait_cnt <= sat_inc(wait_cnt);
      else
        wait_cnt <= 4'd0;
      case (state)
        S_NORM: if (o_ext_gnt && i_ext_lock) state <= S_LOCK;
        S_LOCK: if (!i_ext_lock) state <= S_NORM;
        default: state <= S_NORM;
      endcase
    end
  end

  // Read owner needs no reset: it is only observed while rd_vld_p1 is set
  always_ff @(posedge i_clk) begin
    rd_ext_p1 <= o_ext_gnt;
  end

  // Stage p1: read return steered to the owning port; a reset cycle suppresses it
  assign o_cpu_rvalid = ~i_rst & rd_vld_p1 & ~rd_ext_p1;
  assign o_ext_rvalid = ~i_rst & rd_vld_p1 & rd_ext_p1;
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
  assign o_ext_rdata  = o_ext_rvalid ? i_mem_rdata : '0;

endmodule
